// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
package ram_arb_pkg;

   localparam int RAM_ADDR_W = 4;
   localparam int RAM_DATA_W = 8;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_ISSUE,
      ST_RD_CAPT,
      ST_RD_ACK
   } ram_arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between the CPU and loader requests.
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic i_cpu_req,
   input  logic i_ldr_req,
   input  logic i_pref,
   output logic o_valid,
   output logic o_port
);

   // On a collision the preferred port wins; a lone request always wins.
   always_comb begin
      o_valid = i_cpu_req | i_ldr_req;
      if (i_cpu_req && i_ldr_req) begin
         o_port = i_pref;
      end else if (i_ldr_req) begin
         o_port = PORT_LDR;
      end else begin
         o_port = PORT_CPU;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the registered-read program/data RAM between the CPU and loader ports.
// Build option RAM_ARB_RR_EN: round-robin arbitration; undefined gives fixed loader priority.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | arbitrate; latch winner's addr/wdata and owner
// ST_WR       | ram_we strobe, owner ack
// ST_RD_ISSUE | ram_oe, RAM registers the addressed word at end of cycle
// ST_RD_CAPT  | ram_oe held, ram_rdata valid and captured into r_rdata_q
// ST_RD_ACK   | owner ack, rdata outputs show the captured word
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ram_we,
   output logic              ram_oe,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   ram_arb_state_t    r_state;
   ram_arb_state_t    w_next;
   logic              w_pref;
   logic              w_gnt_valid;
   logic              w_gnt_port;
   logic              w_gnt_we;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [DATA_W-1:0] w_gnt_wdata;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata_q;
   logic              r_owner;
   logic              w_ack;

`ifdef RAM_ARB_RR_EN
   logic              r_ptr;
   assign w_pref = r_ptr;
`else
   assign w_pref = PORT_LDR;
`endif

   ram_arb_pick u_pick (
      .i_cpu_req (cpu_req),
      .i_ldr_req (ldr_req),
      .i_pref    (w_pref),
      .o_valid   (w_gnt_valid),
      .o_port    (w_gnt_port)
   );

   assign w_gnt_we    = (w_gnt_port == PORT_LDR) ? ldr_we    : cpu_we;
   assign w_gnt_addr  = (w_gnt_port == PORT_LDR) ? ldr_addr  : cpu_addr;
   assign w_gnt_wdata = (w_gnt_port == PORT_LDR) ? ldr_wdata : cpu_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               w_next = w_gnt_we ? ST_WR : ST_RD_ISSUE;
            end
         end
         ST_WR:       w_next = ST_IDLE;
         ST_RD_ISSUE: w_next = ST_RD_CAPT;
         ST_RD_CAPT:  w_next = ST_RD_ACK;
         ST_RD_ACK:   w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata_q <= '0;
         r_owner   <= PORT_LDR;
`ifdef RAM_ARB_RR_EN
         r_ptr     <= PORT_CPU;
`endif
      end else begin
         if (r_state == ST_IDLE && w_gnt_valid) begin
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_wdata;
            r_owner <= w_gnt_port;
`ifdef RAM_ARB_RR_EN
            r_ptr   <= ~w_gnt_port;
`endif
         end
         if (r_state == ST_RD_CAPT) begin
            r_rdata_q <= ram_rdata;
         end
      end
   end

   // ram_rdata is only driven while ram_oe is high, so it is sampled in RD_CAPT alone.
   always_comb begin
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      w_ack     = 1'b0;
      busy      = (r_state != ST_IDLE);
      case (r_state)
         ST_WR: begin
            ram_we    = 1'b1;
            ram_addr  = r_addr;
            ram_wdata = r_wdata;
            w_ack     = 1'b1;
         end
         ST_RD_ISSUE, ST_RD_CAPT: begin
            ram_oe   = 1'b1;
            ram_addr = r_addr;
         end
         ST_RD_ACK: w_ack = 1'b1;
         default: ;
      endcase
   end

   assign cpu_ack   = w_ack & (r_owner == PORT_CPU);
   assign ldr_ack   = w_ack & (r_owner == PORT_LDR);
   assign cpu_rdata = r_rdata_q;
   assign ldr_rdata = r_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack;
   logic [3:0] cpu_addr, ldr_addr, ram_addr;
   logic [7:0] cpu_wdata, cpu_rdata, ldr_wdata, ldr_rdata, ram_wdata;
   logic       ram_we, ram_oe, busy;
   wire  [7:0] ram_rdata;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   // RAM device: synchronous write, registered read, tri-stated output
   logic [7:0] ram_mem [16];
   logic [7:0] ram_q;
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_oe) ram_q <= ram_mem[ram_addr];
   end
   assign ram_rdata = ram_oe ? ram_q : 8'bz;

   typedef struct packed {
      logic       we;
      logic [3:0] addr;
      logic [7:0] data;
      logic       b2b;
      logic [3:0] gap;
   } txn_t;

   txn_t       tq [2][64];
   logic [6:0] head [2];
   logic [6:0] tail [2];
   logic       req_v [2];
   txn_t       cur [2];
   int         start_at [2];

   logic [7:0] m_mem [16];
   bit         m_active;
   int         m_start;
   logic       m_port, m_we, m_pref;
   logic [3:0] m_addr;
   logic [7:0] m_data;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int glog[$];
   int cacyc[$];
   int lacyc[$];
   int rlog[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive();
      cpu_req = req_v[0]; cpu_we = cur[0].we; cpu_addr = cur[0].addr; cpu_wdata = cur[0].data;
      ldr_req = req_v[1]; ldr_we = cur[1].we; ldr_addr = cur[1].addr; ldr_wdata = cur[1].data;
   endtask

   task automatic enq(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d,
                      input bit b2b, input int gap);
      tq[p][tail[p][5:0]] = '{we: we, addr: a, data: d, b2b: b2b, gap: 4'(gap)};
      tail[p] = tail[p] + 7'd1;
   endtask

   task automatic clear_ports();
      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; head[i] = '0; tail[i] = '0; start_at[i] = 0; cur[i] = '0;
      end
      drive();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_ram_we"}, 32'(ram_we), 0);
      chk({tag, "_ram_oe"}, 32'(ram_oe), 0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
      chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
      chk({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
      chk({tag, "_ldr_ack"}, 32'(ldr_ack), 0);
      chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
      chk({tag, "_ldr_rdata"}, 32'(ldr_rdata), 0);
   endtask

   // Called just after a falling edge: asserts reset mid-cycle, holds it two cycles.
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 chk_all_zero(tag);
      clear_ports();
      m_active = 1'b0;
      m_pref   = PORT_CPU;
      @(negedge clk);
      @(negedge clk);
      cyc += 2;
      rst_n = 1'b1;
   endtask

   // One cycle: check outputs against the model, then act as both requesters.
   task automatic step();
      bit         was_idle, e_busy, e_we, e_oe, e_ack, w;
      bit         ack_o [2];
      int         k;
      @(negedge clk);
      cyc++;
      was_idle = !m_active;
      k = m_active ? cyc - m_start : 0;
      e_busy = m_active && k > 0;
      e_we   = m_active && m_we && k == 1;
      e_oe   = m_active && !m_we && (k == 1 || k == 2);
      e_ack  = e_we || (m_active && !m_we && k == 3);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_oe", 32'(ram_oe), 32'(e_oe));
      chk("cpu_ack", 32'(cpu_ack), 32'(e_ack && m_port == PORT_CPU));
      chk("ldr_ack", 32'(ldr_ack), 32'(e_ack && m_port == PORT_LDR));
      chk("we_oe_excl", 32'(ram_we & ram_oe), 0);
      chk("ack_excl", 32'(cpu_ack & ldr_ack), 0);
      if (!e_busy) chk("idle_addr", 32'(ram_addr), 0);
      if (!e_busy) chk("idle_wdata", 32'(ram_wdata), 0);
      if (e_we || e_oe) chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_data));
      if (e_ack && !m_we) begin
         if (m_port == PORT_CPU) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_mem[m_addr]));
         else chk("ldr_rdata", 32'(ldr_rdata), 32'(m_mem[m_addr]));
         if (m_port == PORT_CPU && cpu_ack) rlog.push_back(int'(cpu_rdata));
      end
      if (e_we) m_mem[m_addr] = m_data;
      if (m_active && k == (m_we ? 1 : 3)) m_active = 1'b0;

      ack_o[0] = cpu_ack;
      ack_o[1] = ldr_ack;
      if (cpu_ack) begin glog.push_back(0); cacyc.push_back(cyc); end
      if (ldr_ack) begin glog.push_back(1); lacyc.push_back(cyc); end
      for (int i = 0; i < 2; i++) begin
         bit p;
         p = i[0];
         if (req_v[p] && ack_o[p]) begin
            head[p] = head[p] + 7'd1;
            if (cur[p].b2b && head[p] != tail[p]) cur[p] = tq[p][head[p][5:0]];
            else begin
               req_v[p] = 1'b0;
               start_at[p] = cyc + 1 + int'(cur[p].gap);
            end
         end else if (!req_v[p] && head[p] != tail[p] && cyc >= start_at[p]) begin
            cur[p] = tq[p][head[p][5:0]];
            req_v[p] = 1'b1;
         end
      end
      drive();

      if (was_idle && (req_v[0] || req_v[1])) begin
`ifdef RAM_ARB_RR_EN
         w = (req_v[0] && req_v[1]) ? m_pref : req_v[1];
`else
         w = req_v[1];
`endif
         m_active = 1'b1;
         m_start  = cyc;
         m_port   = w;
         m_we     = cur[w].we;
         m_addr   = cur[w].addr;
         m_data   = cur[w].data;
         m_pref   = ~w;
      end
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n;
      n = 0;
      while ((head[0] != tail[0] || head[1] != tail[1] || req_v[0] || req_v[1] || m_active)
             && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_in_budget"}, 32'(n < budget), 1);
      step();
      step();
      clear_ports();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n, exp_p;
      m_active = 1'b0;
      m_pref   = PORT_CPU;
      clear_ports();
      do_reset("rst0");

      // Load every word so later reads have defined contents
      for (int i = 0; i < 16; i++) enq(1'b1, 1'b1, 4'(i), 8'($urandom), 1'b1, 0);
      run_until_done("fill", 200);

      // Loader write then CPU read of the same word
      enq(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 0);
      run_until_done("ldr_wr", 50);
      rlog.delete();
      enq(1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 0);
      run_until_done("cpu_rd", 50);
      chk("cpu_rd_a5", 32'(rlog.size() == 1 ? rlog[0] : -1), 32'h000000A5);

      // Reset while the read sits in RD_CAPT
      enq(1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 0);
      n = 0;
      while (!(m_active && cyc - m_start == 2) && n < 50) begin step(); n++; end
      chk("reach_rd_capt", 32'(n < 50), 1);
      do_reset("rst_mid");
      for (int i = 0; i < 6; i++) step();

      // Simultaneous requests: CPU read addr 0, loader write 0x3C to addr 0
      do_reset("rst_c1");
      glog.delete();
      rlog.delete();
      enq(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 0);
      enq(1'b1, 1'b1, 4'd0, 8'h3C, 1'b0, 0);
      run_until_done("coll1", 100);
      chk("coll1_n", 32'(glog.size()), 2);
`ifdef RAM_ARB_RR_EN
      exp_p = 0;
`else
      exp_p = 1;
      chk("coll1_cpu_3c", 32'(rlog.size() == 1 ? rlog[0] : -1), 32'h0000003C);
`endif
      if (glog.size() == 2) begin
         chk("coll1_first", 32'(glog[0]), 32'(exp_p));
         chk("coll1_second", 32'(glog[1]), 32'(1 - exp_p));
      end

      // Both ports hold req for four transactions each
      do_reset("rst_c4");
      glog.delete();
      for (int i = 0; i < 4; i++) begin
         enq(1'b0, 1'(i % 2), 4'(i + 8), 8'($urandom), 1'b1, 0);
         enq(1'b1, 1'((i + 1) % 2), 4'(i + 12), 8'($urandom), 1'b1, 0);
      end
      run_until_done("coll4", 200);
      chk("coll4_n", 32'(glog.size()), 8);
      for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_RR_EN
         exp_p = i % 2;
`else
         exp_p = (i < 4) ? 1 : 0;
`endif
         if (i < glog.size()) chk("coll4_order", 32'(glog[i]), 32'(exp_p));
      end

      // CPU back-to-back: 16 writes then 16 reads
      rlog.delete();
      cacyc.delete();
      for (int i = 0; i < 16; i++) enq(1'b0, 1'b1, 4'(i), 8'(i + 1), 1'b1, 0);
      for (int i = 0; i < 16; i++) enq(1'b0, 1'b0, 4'(i), 8'h00, 1'b1, 0);
      run_until_done("b2b", 300);
      chk("b2b_nrd", 32'(rlog.size()), 16);
      for (int i = 0; i < 16; i++)
         if (i < rlog.size()) chk("b2b_rdata", 32'(rlog[i]), 32'(i + 1));
      for (int i = 0; i < 15; i++)
         if (i + 1 < cacyc.size()) chk("b2b_wr_spacing", 32'(cacyc[i + 1] - cacyc[i]), 2);

      // Loader raises req while the CPU read is in RD_ISSUE
      glog.delete();
      cacyc.delete();
      lacyc.delete();
      enq(1'b0, 1'b0, 4'd7, 8'h00, 1'b0, 0);
      enq(1'b1, 1'b1, 4'd7, 8'h99, 1'b0, 0);
      start_at[1] = cyc + 2;
      run_until_done("late", 100);
      chk("late_n", 32'(glog.size()), 2);
      if (glog.size() == 2) chk("late_first_cpu", 32'(glog[0]), 0);
      if (cacyc.size() == 1 && lacyc.size() == 1)
         chk("late_ldr_delay", 32'(lacyc[0] - cacyc[0]), 2);

      // Random traffic on both ports
      for (int i = 0; i < 40; i++) begin
         enq(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
         enq(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      run_until_done("rand", 4000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
